// File: rtl/clk_freq_monitor.sv
// Frequency monitor for the divided PLL output. It counts meas_clk edges per gate
// window of clk cycles, qualifies lock and drives a registered downstream reset.
module clk_freq_monitor #(
  parameter int GATE_CYCLES  = 100000,
  parameter int EXP_COUNT    = 40,
  parameter int TOL          = 1,
  parameter int LOCK_WINDOWS = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             meas_clk,
  input  logic             clear_fault,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic             locked,
  output logic             rst_out_n,
  output logic             fault
);
  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int RUN_W  = $clog2(LOCK_WINDOWS + 1);
  localparam int WIDE_W = CNT_W + 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(LOCK_WINDOWS);
  localparam logic [RUN_W-1:0]  RUN_ZERO  = {RUN_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [WIDE_W-1:0] LO_BOUND  = (EXP_COUNT >= TOL) ? WIDE_W'(EXP_COUNT - TOL) : {WIDE_W{1'b0}};
  localparam logic [WIDE_W-1:0] HI_BOUND  = WIDE_W'(EXP_COUNT + TOL);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DISCARD = 2'd1,
    ACQUIRE = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  function automatic logic in_window(input logic [CNT_W-1:0] count);
    logic [WIDE_W-1:0] wide;
    wide = {1'b0, count};
    return (wide >= LO_BOUND) && (wide <= HI_BOUND);
  endfunction

  state_t             state_r, state_s;
  logic               s1_r, s2_r, s3_r;
  logic [GATE_W-1:0]  gate_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [RUN_W-1:0]   run_r, run_s;
  logic               fault_set_s;

  wire                edge_s       = s2_r & ~s3_r;
  wire                terminal_s   = (state_r != IDLE) && (gate_r == GATE_LAST);
  wire                close_s      = terminal_s & en;
  wire [CNT_W-1:0]    closed_cnt_s = (edge_s && (cnt_r != CNT_MAX)) ? cnt_r + CNT_W'(1) : cnt_r;
  wire                good_s       = in_window(closed_cnt_s);
  wire [RUN_W-1:0]    run_inc_s    = (run_r < RUN_MAX) ? run_r + RUN_W'(1) : run_r;

  // meas_clk synchroniser and edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= meas_clk;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Gate and edge counters; the edge of the terminal cycle already sits in closed_cnt_s
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_r <= {GATE_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end else if (!en || (state_r == IDLE) || terminal_s) begin
      gate_r <= {GATE_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      gate_r <= gate_r + GATE_W'(1);
      cnt_r  <= closed_cnt_s;
    end
  end

  // Next-state, good-run and fault-set decode
  always_comb begin
    state_s     = state_r;
    run_s       = run_r;
    fault_set_s = 1'b0;
    if (!en) begin
      state_s = IDLE;
      run_s   = RUN_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = DISCARD;
          run_s   = RUN_ZERO;
        end
        DISCARD: begin
          if (close_s) state_s = ACQUIRE;
          else         state_s = DISCARD;
        end
        ACQUIRE: begin
          if (close_s && good_s) begin
            run_s = run_inc_s;
            if (run_inc_s == RUN_MAX) state_s = LOCKED;
            else                      state_s = ACQUIRE;
          end else if (close_s) begin
            run_s = RUN_ZERO;
          end else begin
            run_s = run_r;
          end
        end
        LOCKED: begin
          if (close_s && good_s) begin
            run_s = run_inc_s;
          end else if (close_s) begin
            run_s       = RUN_ZERO;
            state_s     = ACQUIRE;
            fault_set_s = 1'b1;
          end else begin
            run_s = run_r;
          end
        end
        default: begin
          state_s = IDLE;
          run_s   = RUN_ZERO;
        end
      endcase
    end
  end

  // State, good-run counter and registered outputs; locked tracks the state exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      run_r      <= RUN_ZERO;
      meas_count <= {CNT_W{1'b0}};
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      rst_out_n  <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state_r    <= state_s;
      run_r      <= run_s;
      meas_valid <= close_s;
      if (close_s) meas_count <= closed_cnt_s;
      else         meas_count <= meas_count;
      locked     <= (state_s == LOCKED);
      rst_out_n  <= locked;
      if (fault_set_s)      fault <= 1'b1;
      else if (clear_fault) fault <= 1'b0;
      else                  fault <= fault;
    end
  end
endmodule

// File: doc/clk_freq_monitor.md
Name: clk_freq_monitor

Overview:
- Sits directly downstream of the Gowin rPLL wrapper. It checks the divided PLL output (clkoutd, nominally 40 kHz) against the 100 MHz system clock.
- It counts meas_clk rising edges inside a fixed gate window of system-clock cycles and compares each count with the expected value plus or minus a tolerance.
- It declares frequency lock after N consecutive good windows and produces a registered active-low reset that holds the downstream Costas-loop logic in reset until lock.
- It also reports the raw count each window and a sticky fault flag when lock is lost.

Parameters:
- GATE_CYCLES, 100000, gate window length in clk cycles (1 ms at 100 MHz).
- EXP_COUNT, 40, expected meas_clk rising edges per window.
- TOL, 1, allowed absolute deviation from EXP_COUNT (inclusive).
- LOCK_WINDOWS, 4, consecutive good windows required to declare lock.
- CNT_W, 16, width of the edge counter and the count output.

Ports:
- clk, input, 1, system clock (100 MHz).
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, monitor enable; 0 holds the block idle.
- meas_clk, input, 1, clock under test (asynchronous to clk, slower than clk/4).
- clear_fault, input, 1, single-cycle pulse that clears fault.
- meas_count, output, CNT_W, edge count of the last completed window.
- meas_valid, output, 1, one-cycle pulse when meas_count updates.
- locked, output, 1, frequency lock indicator.
- rst_out_n, output, 1, active-low reset for downstream logic; it is low whenever the block is not locked.
- fault, output, 1, sticky flag: lock was lost.

Behaviour:
- Reset values (async on rst_n=0): meas_count=0, meas_valid=0, locked=0, rst_out_n=0, fault=0, all counters 0, synchroniser FFs 0, state IDLE.
- Input sync: meas_clk passes through 2 FFs (s1, s2) plus s3 for edge detect. A rising edge is s2=1 and s3=0. Latency from a pin edge to counting is 3 clk cycles.
- Gate counter: runs 0..GATE_CYCLES-1 while the state is not IDLE. The terminal cycle is gate==GATE_CYCLES-1.
- Edge counter: increments on each detected edge and saturates at 2^CNT_W-1.
  - On the terminal cycle, an edge detected that same cycle is included in the closing window.
  - The counter then restarts at 0 for the next window.
- Window close: on the cycle after the terminal cycle, meas_count loads the closed count and meas_valid=1 for exactly 1 cycle. This applies in all non-IDLE states, including DISCARD.
- Window evaluation: good = (count >= EXP_COUNT-TOL) and (count <= EXP_COUNT+TOL). The lower bound clamps at 0. Arithmetic is unsigned and CNT_W+1 bits wide.
- Good-run counter: increments on each good window, saturating at LOCK_WINDOWS. It clears to 0 on a bad window, on entering IDLE, and on entering DISCARD.
- State machine (state updates on the same edge that pulses meas_valid):
  - IDLE: counters held at 0; locked=0. When en=1, go to DISCARD on the next cycle.
  - DISCARD: the first window is measured and reported but not evaluated, because the synchroniser and meas_clk phase are unsettled. At window close, go to ACQUIRE.
  - ACQUIRE: locked=0; each window is evaluated. When the good-run counter reaches LOCK_WINDOWS, go to LOCKED.
  - LOCKED: locked=1. On any bad window, go to ACQUIRE (immediate loss of lock), set fault=1, and clear the good-run counter.
  - Any state: if en=0, go to IDLE on the next cycle. The in-progress window is abandoned with no meas_valid. fault is preserved.
- locked is a registered output of the state: 1 exactly while the state is LOCKED. rst_out_n is registered from locked, so it lags locked by 1 cycle on both rise and fall.
- fault: set on a LOCKED to ACQUIRE transition and cleared by clear_fault.
  - If set and clear occur in the same cycle, set wins.
  - fault is not set on an en-driven exit from LOCKED.
- Reset mid-window: all state is lost immediately; after rst_n rises, the block restarts from IDLE, then DISCARD.
- A stuck meas_clk (no edges) gives count 0, which is a bad window. A meas_clk faster than clk/4 is out of scope; the count is undefined but the block must not hang.

Test Plan (GATE_CYCLES=100, EXP_COUNT=10, TOL=1, LOCK_WINDOWS=3, CNT_W=8):
- Reset, then en=1 with meas_clk period 10 clk cycles → a DISCARD window is reported (meas_valid pulses), then 3 good windows with meas_count 9..11. locked rises on the 4th meas_valid cycle, and rst_out_n rises 1 cycle later.
- After lock, change meas_clk to a period of 8 clk cycles (12 or 13 edges) → on that meas_valid: locked=0, fault=1, and rst_out_n falls 1 cycle later. Restoring a period of 10 relocks after 3 good windows while fault stays 1. Pulsing clear_fault then gives fault=0.
- meas_clk held at 0 → every window reports meas_count=0 and locked never asserts. Tolerance edge: exactly 9 and exactly 11 edges count as good; 8 and 12 count as bad.
- While LOCKED, drop en for 5 cycles mid-window → locked=0 on the next cycle, no meas_valid, and fault stays 0. Re-enabling runs DISCARD and then a full reacquire.
- Assert rst_n=0 asynchronously mid-window while LOCKED → all outputs go to reset values immediately, without waiting for a clk edge.
- Simultaneous clear_fault and lock loss in the same cycle → fault=1.
